// File: rtl/vga_if.sv
// Pixel-side bundle of the VGA timing stage: renderer colour in, timing and blanked colour out.
// The timing stage drives every signal except pixel_rgb, which the renderer returns combinationally.
interface vga_if;
  logic [7:0] pixel_rgb;
  logic       pixel_tick;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       video_on;
  logic       hsync;
  logic       vsync;
  logic [7:0] rgb_out;
  logic       frame_start;

  // pixel_tick is a qualifier strobe, not a handshake: there is no ready/back-pressure.
  // The renderer must hold pixel_rgb valid for the current pixel_x/pixel_y on every
  // clk where pixel_tick is high.
  modport master (
    input  pixel_rgb,
    output pixel_tick, pixel_x, pixel_y, video_on, hsync, vsync, rgb_out, frame_start
  );

  modport slave (
    output pixel_rgb,
    input  pixel_tick, pixel_x, pixel_y, video_on, hsync, vsync, rgb_out, frame_start
  );
endinterface

// File: rtl/vga_sync_rgb.sv
// VGA pixel-timing stage: clock divider, h/v counters, registered sync and blanked 3-3-2 colour.
// Sync, colour and frame_start are registered, so they lag pixel_x/pixel_y by one pixel.
module vga_sync_rgb #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  vga_if.master vga
);

  localparam logic [3:0]  DIV_LAST   = 4'(CLK_DIV - 1);
  localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0] H_SS       = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SE       = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] H_LAST     = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
  localparam logic [10:0] V_SS       = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SE       = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [10:0] V_LAST     = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [3:0] div_q, div_d;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic [7:0] rgb_q, rgb_d;
  logic       fs_q, fs_d;

  logic        tick;
  logic        active;
  logic        hs_raw;
  logic        vs_raw;
  logic        h_last;
  logic        v_last;
  logic [10:0] hx;
  logic [10:0] vy;

  assign hx     = {1'b0, h_q};
  assign vy     = {1'b0, v_q};
  assign tick   = (div_q == DIV_LAST);
  assign active = (hx < H_ACT) && (vy < V_ACT);
  assign hs_raw = (hx >= H_SS) && (hx <= H_SE);
  assign vs_raw = (vy >= V_SS) && (vy <= V_SE);
  assign h_last = (hx == H_LAST);
  assign v_last = (vy == V_LAST);

  always_comb begin
    div_d = tick ? 4'd0 : div_q + 4'd1;
    h_d   = h_q;
    v_d   = v_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    rgb_d = rgb_q;
    // frame_start is re-evaluated every clk so it stays a single-clk pulse.
    fs_d  = tick && h_last && v_last;
    if (tick) begin
      if (h_last) begin
        h_d = 10'd0;
        v_d = v_last ? 10'd0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
      // Outputs are loaded from the pre-increment position, giving the one-pixel lag.
      hs_d  = hs_raw ? SYNC_POL : ~SYNC_POL;
      vs_d  = vs_raw ? SYNC_POL : ~SYNC_POL;
      rgb_d = active ? vga.pixel_rgb : 8'h00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= 4'd0;
      h_q   <= 10'd0;
      v_q   <= 10'd0;
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
      rgb_q <= 8'h00;
      fs_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      rgb_q <= rgb_d;
      fs_q  <= fs_d;
    end
  end

  assign vga.pixel_tick  = tick;
  assign vga.pixel_x     = h_q;
  assign vga.pixel_y     = v_q;
  assign vga.video_on    = active;
  assign vga.hsync       = hs_q;
  assign vga.vsync       = vs_q;
  assign vga.rgb_out     = rgb_q;
  assign vga.frame_start = fs_q;

endmodule

// File: tb/tb_vga_sync_rgb.sv
// Directed bench for vga_sync_rgb: a default 640x480 instance for line timing and a
// tiny-parameter instance (CLK_DIV=1, SYNC_POL=1) for full-frame timing.
`timescale 1ns/1ps
module tb_vga_sync_rgb;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic       rgb_mode  = 1'b0;
  logic [7:0] rgb_const = 8'h00;

  vga_if ifa ();
  vga_if ifb ();

  // Renderer models: constant or pixel_x colour for the default instance, {y,x} for the tiny one.
  assign ifa.pixel_rgb = rgb_mode ? ifa.pixel_x[7:0] : rgb_const;
  assign ifb.pixel_rgb = {ifb.pixel_y[3:0], ifb.pixel_x[3:0]};

  vga_sync_rgb dut (
    .clk (clk),
    .rst (rst),
    .vga (ifa)
  );

  vga_sync_rgb #(
    .CLK_DIV (1), .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1), .SYNC_POL (1'b1)
  ) dut_s (
    .clk (clk),
    .rst (rst),
    .vga (ifb)
  );

  // ---------------- driver tasks ----------------
  task automatic reset_pulse();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_x(input int target, input int budget);
    int n;
    n = 0;
    while (ifa.pixel_x !== 10'(target) && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (ifa.pixel_x !== 10'(target)) begin
      n_fail++;
      $display("FAIL wait_x: pixel_x=%0d required %0d within %0d clks", ifa.pixel_x, target, budget);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rgb_mode  = 1'b0;
    rgb_const = 8'h81;
    rst = 1'b1;
    @(negedge clk);
    n_checks += 7;
    if (ifa.pixel_x !== 10'd0) begin n_fail++; $display("FAIL rst_x: got %0d exp 0", ifa.pixel_x); end
    if (ifa.pixel_y !== 10'd0) begin n_fail++; $display("FAIL rst_y: got %0d exp 0", ifa.pixel_y); end
    if (ifa.hsync !== 1'b1) begin n_fail++; $display("FAIL rst_hsync: got %b exp 1", ifa.hsync); end
    if (ifa.vsync !== 1'b1) begin n_fail++; $display("FAIL rst_vsync: got %b exp 1", ifa.vsync); end
    if (ifa.rgb_out !== 8'h00) begin n_fail++; $display("FAIL rst_rgb: got %h exp 00", ifa.rgb_out); end
    if (ifa.frame_start !== 1'b0) begin n_fail++; $display("FAIL rst_fs: got %b exp 0", ifa.frame_start); end
    if (ifa.pixel_tick !== 1'b0) begin n_fail++; $display("FAIL rst_tick: got %b exp 0", ifa.pixel_tick); end

    rst = 1'b0;
    @(negedge clk);
    n_checks += 2;
    if (ifa.pixel_tick !== 1'b1) begin n_fail++; $display("FAIL rel_tick1: got %b exp 1", ifa.pixel_tick); end
    if (ifa.pixel_x !== 10'd0) begin n_fail++; $display("FAIL rel_x1: got %0d exp 0", ifa.pixel_x); end
    @(negedge clk);
    n_checks += 2;
    if (ifa.pixel_tick !== 1'b0) begin n_fail++; $display("FAIL rel_tick2: got %b exp 0", ifa.pixel_tick); end
    if (ifa.pixel_x !== 10'd1) begin n_fail++; $display("FAIL rel_x2: got %0d exp 1", ifa.pixel_x); end

    // Mid-line reset at h=300 with a visible colour registered.
    wait_x(300, 1000);
    n_checks++;
    if (ifa.rgb_out !== 8'h81) begin n_fail++; $display("FAIL mid_rgb: got %h exp 81", ifa.rgb_out); end
    rst = 1'b1;
    #1;
    n_checks += 4;
    if (ifa.pixel_x !== 10'd0) begin n_fail++; $display("FAIL async_x: got %0d exp 0", ifa.pixel_x); end
    if (ifa.pixel_y !== 10'd0) begin n_fail++; $display("FAIL async_y: got %0d exp 0", ifa.pixel_y); end
    if (ifa.rgb_out !== 8'h00) begin n_fail++; $display("FAIL async_rgb: got %h exp 00", ifa.rgb_out); end
    if (ifa.hsync !== 1'b1) begin n_fail++; $display("FAIL async_hsync: got %b exp 1", ifa.hsync); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (ifa.pixel_x !== 10'd1) begin n_fail++; $display("FAIL restart_x: got %0d exp 1", ifa.pixel_x); end

    // Reset inside the sync pulse must end the pulse at once.
    wait_x(700, 2000);
    n_checks++;
    if (ifa.hsync !== 1'b0) begin n_fail++; $display("FAIL pre_hsync: got %b exp 0", ifa.hsync); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (ifa.hsync !== 1'b1) begin n_fail++; $display("FAIL cut_hsync: got %b exp 1", ifa.hsync); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_line_timing();
    int m;
    logic [9:0] exp_x;
    logic exp_tick, exp_hs;
    rgb_mode = 1'b0;
    rgb_const = 8'h00;
    reset_pulse();
    // Negedge k after release: h = k/2, tick on odd k, hsync loaded from h = k/2 - 1.
    for (int k = 1; k <= 1610; k++) begin
      @(negedge clk);
      m = k / 2;
      exp_x    = 10'(m % 800);
      exp_tick = logic'(k % 2 == 1);
      exp_hs   = ~logic'(m >= 1 && ((m - 1) % 800) >= 656 && ((m - 1) % 800) <= 751);
      n_checks += 4;
      if (ifa.pixel_x !== exp_x) begin n_fail++; $display("FAIL line_x k=%0d: got %0d exp %0d", k, ifa.pixel_x, exp_x); end
      if (ifa.pixel_tick !== exp_tick) begin n_fail++; $display("FAIL line_tick k=%0d: got %b exp %b", k, ifa.pixel_tick, exp_tick); end
      if (ifa.hsync !== exp_hs) begin n_fail++; $display("FAIL line_hsync k=%0d x=%0d: got %b exp %b", k, ifa.pixel_x, ifa.hsync, exp_hs); end
      if (ifa.frame_start !== 1'b0) begin n_fail++; $display("FAIL line_fs k=%0d: got %b exp 0", k, ifa.frame_start); end
      if (k == 1599 || k == 1600) begin
        n_checks++;
        if (ifa.pixel_y !== 10'(k / 1600)) begin n_fail++; $display("FAIL line_y k=%0d: got %0d exp %0d", k, ifa.pixel_y, k / 1600); end
      end
    end
  endtask

  task automatic test_blanking();
    int p;
    logic [7:0] exp_rgb;
    rgb_mode  = 1'b0;
    rgb_const = 8'hFF;
    reset_pulse();
    for (int k = 1; k <= 1620; k++) begin
      @(negedge clk);
      if (k == 1400) rgb_const = 8'h3C;
      p = k / 2 - 1;
      if (p < 0 || (p % 800) >= 640) exp_rgb = 8'h00;
      else if (p < 800)              exp_rgb = 8'hFF;
      else                           exp_rgb = 8'h3C;
      n_checks++;
      if (ifa.rgb_out !== exp_rgb) begin n_fail++; $display("FAIL blank_rgb k=%0d x=%0d: got %h exp %h", k, ifa.pixel_x, ifa.rgb_out, exp_rgb); end
    end
  endtask

  task automatic test_alignment();
    int p;
    logic [7:0] exp_rgb;
    rgb_mode = 1'b1;
    reset_pulse();
    for (int k = 1; k <= 1600; k++) begin
      @(negedge clk);
      p = k / 2 - 1;
      exp_rgb = (p >= 0 && p < 640) ? 8'(p) : 8'h00;
      n_checks++;
      if (ifa.rgb_out !== exp_rgb) begin
        n_fail++;
        if (p == 0)        $display("FAIL align_first: got %h exp %h", ifa.rgb_out, exp_rgb);
        else if (p == 639) $display("FAIL align_last: got %h exp %h", ifa.rgb_out, exp_rgb);
        else               $display("FAIL align k=%0d: got %h exp %h", k, ifa.rgb_out, exp_rgb);
      end
    end
    rgb_mode = 1'b0;
  endtask

  task automatic test_small_frame();
    int h, v, ph, pv, fs_count;
    logic exp_hs, exp_vs, exp_on, exp_fs;
    logic [7:0] exp_rgb;
    fs_count = 0;
    rst = 1'b1;
    @(negedge clk);
    n_checks += 3;
    if (ifb.hsync !== 1'b0) begin n_fail++; $display("FAIL small_rst_hsync: got %b exp 0", ifb.hsync); end
    if (ifb.vsync !== 1'b0) begin n_fail++; $display("FAIL small_rst_vsync: got %b exp 0", ifb.vsync); end
    if (ifb.pixel_tick !== 1'b1) begin n_fail++; $display("FAIL small_rst_tick: got %b exp 1", ifb.pixel_tick); end
    rst = 1'b0;
    // Tiny timing: H_TOTAL=14, V_TOTAL=7, one pixel per clk, active-high syncs.
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      h  = k % 14;
      v  = (k / 14) % 7;
      ph = (k - 1) % 14;
      pv = ((k - 1) / 14) % 7;
      exp_on  = logic'(h < 8 && v < 4);
      exp_hs  = logic'(ph == 10 || ph == 11);
      exp_vs  = logic'(pv == 5);
      exp_rgb = (ph < 8 && pv < 4) ? 8'(pv * 16 + ph) : 8'h00;
      exp_fs  = logic'(k % 98 == 0);
      if (ifb.frame_start === 1'b1) fs_count++;
      n_checks += 7;
      if (ifb.pixel_x !== 10'(h)) begin n_fail++; $display("FAIL small_x k=%0d: got %0d exp %0d", k, ifb.pixel_x, h); end
      if (ifb.pixel_y !== 10'(v)) begin n_fail++; $display("FAIL small_y k=%0d: got %0d exp %0d", k, ifb.pixel_y, v); end
      if (ifb.video_on !== exp_on) begin n_fail++; $display("FAIL small_von k=%0d: got %b exp %b", k, ifb.video_on, exp_on); end
      if (ifb.hsync !== exp_hs) begin n_fail++; $display("FAIL small_hsync k=%0d: got %b exp %b", k, ifb.hsync, exp_hs); end
      if (ifb.vsync !== exp_vs) begin n_fail++; $display("FAIL small_vsync k=%0d: got %b exp %b", k, ifb.vsync, exp_vs); end
      if (ifb.rgb_out !== exp_rgb) begin n_fail++; $display("FAIL small_rgb k=%0d: got %h exp %h", k, ifb.rgb_out, exp_rgb); end
      if (ifb.frame_start !== exp_fs) begin n_fail++; $display("FAIL small_fs k=%0d: got %b exp %b", k, ifb.frame_start, exp_fs); end
    end
    n_checks++;
    if (fs_count != 3) begin n_fail++; $display("FAIL small_fs_count: got %0d exp 3", fs_count); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_line_timing();
    test_blanking();
    test_alignment();
    test_small_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
